if_fetch_queue: RTL

Instruction-fetch stage between the PC register and the ID stage of the pipelined core. It issues instruction-memory reads for the current PC and tells the PC register when to advance. Fetched instructions and their PCs are buffered in a small FIFO so that ID-stage hazard stalls and I-cache misses are decoupled. It also discards wrong-path fetches on a branch flush.

---
 rtl/if_fetch_queue.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues I-memory reads for the current PC and buffers {inst, pc} in a small FIFO toward ID.
// Optional feature: define IFQ_BYPASS_EN for a zero-latency path from imem_rdata_i to ID when the FIFO is empty.
module if_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_i,
    output logic                     pc_write_o,
    input  logic                     flush_i,
    output logic                     imem_ren_o,
    output logic [29:0]              imem_addr_o,
    input  logic                     imem_stall_i,
    input  logic [31:0]              imem_rdata_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [31:0]              id_inst_o,
    output logic [31:0]              id_pc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [31:0]   req_pc_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   inst_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];

    logic          full_s;
    logic          empty_s;
    logic          ren_s;
    logic          fire_s;
    logic          push_s;
    logic          bypass_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [31:0]   fetch_pc_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == {CW{1'b0}});

    // Request generation: a new fetch only from IDLE when there is room; an outstanding miss keeps ren high.
    always_comb begin
        ren_s      = 1'b0;
        fetch_pc_s = 32'd0;
        if (rst) begin
            ren_s      = 1'b0;
            fetch_pc_s = 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ren_s      = ~full_s & ~flush_i;
                    fetch_pc_s = pc_i;
                end
                ST_WAIT, ST_DROP: begin
                    ren_s      = 1'b1;
                    fetch_pc_s = req_pc_r;
                end
                default: begin
                    ren_s      = 1'b0;
                    fetch_pc_s = pc_i;
                end
            endcase
        end
    end

    assign fire_s      = ren_s & ~imem_stall_i;
    assign push_s      = fire_s & (state_r != ST_DROP) & ~flush_i;
    assign imem_ren_o  = ren_s;
    assign imem_addr_o = fetch_pc_s[31:2];
    assign pc_write_o  = push_s;

`ifdef IFQ_BYPASS_EN
    assign bypass_s  = push_s & empty_s & id_ready_i;
    assign id_inst_o = bypass_s ? imem_rdata_i : inst_mem_r[rd_ptr_r];
    assign id_pc_o   = bypass_s ? fetch_pc_s   : pc_mem_r[rd_ptr_r];
`else
    assign bypass_s  = 1'b0;
    assign id_inst_o = inst_mem_r[rd_ptr_r];
    assign id_pc_o   = pc_mem_r[rd_ptr_r];
`endif

    assign id_valid_o = ~empty_s | bypass_s;
    assign wr_en_s    = push_s & ~bypass_s;
    assign rd_en_s    = ~empty_s & id_ready_i & ~flush_i;
    assign count_o    = count_r;

    // Miss tracking: a flush during a stall turns the pending result into one to be thrown away.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ren_s & imem_stall_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (~imem_stall_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (flush_i) begin
                    state_nxt_s = ST_DROP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (~imem_stall_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and held request PC for the duration of a miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            req_pc_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && ren_s && imem_stall_i) begin
                req_pc_r <= pc_i;
            end else begin
                req_pc_r <= req_pc_r;
            end
        end
    end

    // FIFO pointers and occupancy; a flush wins over any simultaneous push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage, cleared on reset so the ID outputs read as zero while held in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= 32'd0;
                pc_mem_r[i]   <= 32'd0;
            end
        end else if (wr_en_s) begin
            inst_mem_r[wr_ptr_r] <= imem_rdata_i;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_s;
        end
    end

endmodule
